// File: rtl/microwave_pkg.sv
//------------------------------------------------------------------------------
// microwave_pkg : types and constants shared by the keypad entry path and main FSM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package microwave_pkg;

  localparam int MAX_DIGITS = 4;

  typedef logic [3:0] bcd_t;

  localparam bcd_t KEY_NONE = 4'hF;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_RELEASE  = 3'd4
  } entry_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_shift_reg.sv
//------------------------------------------------------------------------------
// bcd_shift_reg : 4-digit BCD shift register, new digits enter at d0 (sec_ones)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_shift_reg
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_en,
  input  logic       clr,
  input  logic [3:0] din,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [2:0] count
);

  localparam logic [2:0] COUNT_MAX = 3'(MAX_DIGITS);

  logic [MAX_DIGITS-1:0][3:0] dig_q;
  logic [2:0]                 count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_q   <= '0;
      count_q <= '0;
    end else if (clr) begin
      dig_q   <= '0;
      count_q <= '0;
    end else if (shift_en) begin
      dig_q <= {dig_q[MAX_DIGITS-2:0], din};
      if (count_q < COUNT_MAX) begin
        count_q <= count_q + 3'd1;
      end
    end
  end

  assign d0    = dig_q[0];
  assign d1    = dig_q[1];
  assign d2    = dig_q[2];
  assign d3    = dig_q[3];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
//------------------------------------------------------------------------------
// keypad_entry_ctrl : debounces encoder keys into a 4-digit MM:SS entry
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keypad_entry_ctrl
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_en,
  input  logic       clear,
  input  logic       start,
  input  logic [3:0] D,
  input  logic       valid,
  output logic       enc_enable,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [2:0] digit_count,
  output logic       key_pulse,
  output logic       load
);

  localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] COUNT_MAX = 3'(MAX_DIGITS);

  entry_state_t state_q, state_d;
  bcd_t         key_q, key_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         key_pulse_q, key_pulse_d;
  logic         load_q, load_d;
  logic         shift_en;
  logic         clr_digits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_DISABLED;
      key_q       <= KEY_NONE;
      cnt_q       <= '0;
      key_pulse_q <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      key_pulse_q <= key_pulse_d;
      load_q      <= load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    key_pulse_d = 1'b0;
    load_d      = 1'b0;
    shift_en    = 1'b0;
    clr_digits  = 1'b0;

    if (state_q == ST_DISABLED) begin
      if (entry_en) begin
        state_d = ST_IDLE;
      end
    end else if (!entry_en) begin
      // Losing permission aborts any press in flight; a concurrent cancel still zeroes.
      state_d    = ST_DISABLED;
      clr_digits = clear;
    end else if (clear) begin
      clr_digits = 1'b1;
      state_d    = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            state_d = ST_DEBOUNCE;
            key_d   = D;
            cnt_d   = '0;
          end else if (start && (digit_count != 3'd0)) begin
            load_d = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!valid) begin
            state_d = ST_IDLE;
          end else if (D != key_q) begin
            key_d = D;
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_CAPTURE: begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          if ((key_q <= 4'd9) && (digit_count < COUNT_MAX)) begin
            shift_en    = 1'b1;
            key_pulse_d = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (valid) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  bcd_shift_reg u_digits (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clr      (clr_digits),
    .din      (key_q),
    .d0       (sec_ones),
    .d1       (sec_tens),
    .d2       (min_ones),
    .d3       (min_tens),
    .count    (digit_count)
  );

  assign enc_enable = (state_q != ST_DISABLED);
  assign key_pulse  = key_pulse_q;
  assign load       = load_q;

endmodule

`default_nettype wire
